// File: rtl/store_buffer_if.sv
// Interface bundle for store_buffer: LSU push/load, commit and data-bus signals.
// master = surrounding pipeline/bus, slave = the store buffer itself.
interface store_buffer_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int ROB_ID_WIDTH   = 5,
  parameter int SIZE_WIDTH     = 2
);
  // LSU store push
  logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id;
  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr;
  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_write_size;
  logic [BUS_DATA_WIDTH-1:0] exlsu_stbuf_write_data;
  logic                      exlsu_stbuf_push;
  logic                      stbuf_exlsu_full;
  // LSU load lookup
  logic                      exlsu_stbuf_read_req;
  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_read_addr;
  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_read_size;
  logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data;
  logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback;
  logic                      stbuf_exlsu_bus_ready;
  // Commit
  logic                      commit_stbuf_retire;
  logic [ROB_ID_WIDTH-1:0]   commit_stbuf_rob_id;
  logic                      commit_stbuf_flush;
  // Bus read
  logic                      stbuf_bus_read_req;
  logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr;
  logic [BUS_DATA_WIDTH-1:0] bus_stbuf_read_data;
  logic                      bus_stbuf_read_ready;
  // Bus drain write
  logic                      stbuf_bus_write_req;
  logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size;
  logic [BUS_DATA_WIDTH-1:0] stbuf_bus_write_data;
  logic                      bus_stbuf_write_ack;

  modport master (
    output exlsu_stbuf_rob_id, exlsu_stbuf_write_addr, exlsu_stbuf_write_size,
           exlsu_stbuf_write_data, exlsu_stbuf_push,
           exlsu_stbuf_read_req, exlsu_stbuf_read_addr, exlsu_stbuf_read_size,
           commit_stbuf_retire, commit_stbuf_rob_id, commit_stbuf_flush,
           bus_stbuf_read_data, bus_stbuf_read_ready, bus_stbuf_write_ack,
    input  stbuf_exlsu_full, stbuf_exlsu_bus_data, stbuf_exlsu_bus_data_feedback,
           stbuf_exlsu_bus_ready, stbuf_bus_read_req, stbuf_bus_read_addr,
           stbuf_bus_write_req, stbuf_bus_write_addr, stbuf_bus_write_size,
           stbuf_bus_write_data
  );

  modport slave (
    input  exlsu_stbuf_rob_id, exlsu_stbuf_write_addr, exlsu_stbuf_write_size,
           exlsu_stbuf_write_data, exlsu_stbuf_push,
           exlsu_stbuf_read_req, exlsu_stbuf_read_addr, exlsu_stbuf_read_size,
           commit_stbuf_retire, commit_stbuf_rob_id, commit_stbuf_flush,
           bus_stbuf_read_data, bus_stbuf_read_ready, bus_stbuf_write_ack,
    output stbuf_exlsu_full, stbuf_exlsu_bus_data, stbuf_exlsu_bus_data_feedback,
           stbuf_exlsu_bus_ready, stbuf_bus_read_req, stbuf_bus_read_addr,
           stbuf_bus_write_req, stbuf_bus_write_addr, stbuf_bus_write_size,
           stbuf_bus_write_data
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer between LSU execute and the data bus.
// Speculative stores wait for commit, committed stores drain to the bus in
// order, and loads see the bus word patched with buffered store bytes.
// Optional feature macro: STBUF_FORWARD_EN (defined = byte-merge forwarding,
// undefined = loads to a word with buffered stores stall until drained).
//
// Drain handshake: stbuf_bus_write_req is a valid that stays high with stable
// addr/size/data until the cycle bus_stbuf_write_ack is high; that cycle the
// write is complete and the head entry is released on the following edge.
module store_buffer #(
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int ROB_ID_WIDTH   = 5,
  parameter int SIZE_WIDTH     = 2
) (
  input logic         clk,
  input logic         rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;

  // Entry storage; validity is defined purely by head/count
  logic [ROB_ID_WIDTH-1:0]   ent_rob  [DEPTH];
  logic [ADDR_WIDTH-1:0]     ent_addr [DEPTH];
  logic [SIZE_WIDTH-1:0]     ent_size [DEPTH];
  logic [BUS_DATA_WIDTH-1:0] ent_data [DEPTH];

  ptr_t head, tail, count, ccount;
  ptr_t head_n, tail_n, count_n, ccount_n;
  ptr_t retire_sum;
  logic [PW-1:0] head_idx, tail_idx, retire_idx;
  logic full, do_push, do_ack, do_retire, write_req;

  logic [PW-1:0] slot [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [BUS_DATA_WIDTH-1:0] load_word, shifted;
  logic load_ok;

  assign head_idx   = head[PW-1:0];
  assign tail_idx   = tail[PW-1:0];
  assign retire_sum = head + ccount;
  assign retire_idx = retire_sum[PW-1:0];

  assign full      = (count == ptr_t'(DEPTH));
  assign write_req = (ccount != '0);
  assign do_push   = sb.exlsu_stbuf_push && !full && !sb.commit_stbuf_flush;
  assign do_ack    = write_req && sb.bus_stbuf_write_ack;
  // A retire with nothing uncommitted would break ccount <= count; ignore it
  assign do_retire = sb.commit_stbuf_retire && (ccount != count);

  // Next pointer/counter values; flush rewinds tail to the committed boundary
  always_comb begin
    head_n   = head + ptr_t'(do_ack);
    ccount_n = ccount + ptr_t'(do_retire) - ptr_t'(do_ack);
    tail_n   = tail + ptr_t'(do_push);
    count_n  = count + ptr_t'(do_push) - ptr_t'(do_ack);
    if (sb.commit_stbuf_flush) begin
      tail_n  = head_n + ccount_n;
      count_n = ccount_n;
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ccount <= '0;
    end else begin
      head   <= head_n;
      tail   <= tail_n;
      count  <= count_n;
      ccount <= ccount_n;
    end
  end

  // Entry write at tail on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      ent_rob[tail_idx]  <= sb.exlsu_stbuf_rob_id;
      ent_addr[tail_idx] <= sb.exlsu_stbuf_write_addr;
      ent_size[tail_idx] <= sb.exlsu_stbuf_write_size;
      ent_data[tail_idx] <= sb.exlsu_stbuf_write_data;
    end
  end

`ifndef SYNTHESIS
  // Retire must name the oldest uncommitted store
  always_ff @(posedge clk) begin
    if (!rst && sb.commit_stbuf_retire) begin
      assert ((ccount != count) && (ent_rob[retire_idx] == sb.commit_stbuf_rob_id))
        else $error("store_buffer: retire rob_id does not match oldest uncommitted store");
    end
  end
`endif

  // Drain outputs come from the head entry, zero when idle
  assign sb.stbuf_exlsu_full     = full;
  assign sb.stbuf_bus_write_req  = write_req;
  assign sb.stbuf_bus_write_addr = write_req ? ent_addr[head_idx] : '0;
  assign sb.stbuf_bus_write_size = write_req ? ent_size[head_idx] : '0;
  assign sb.stbuf_bus_write_data = write_req ? ent_data[head_idx] : '0;

  // Bus read pass-through
  assign sb.stbuf_bus_read_req   = sb.exlsu_stbuf_read_req;
  assign sb.stbuf_bus_read_addr  = {sb.exlsu_stbuf_read_addr[ADDR_WIDTH-1:2], 2'b00};
  assign sb.stbuf_exlsu_bus_data = sb.bus_stbuf_read_data;

  // Per age slot (0 = oldest): physical index and same-word hit for the load
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot[k] = PW'(head + ptr_t'(k));
      hit[k]  = (ptr_t'(k) < count) &&
                (ent_addr[slot[k]][ADDR_WIDTH-1:2] == sb.exlsu_stbuf_read_addr[ADDR_WIDTH-1:2]);
    end
  end

`ifdef STBUF_FORWARD_EN
  logic [BUS_DATA_WIDTH-1:0] merged, lanes;
  logic [3:0] bmask;

  function automatic logic [3:0] byte_mask(input logic [1:0] off,
                                           input logic [SIZE_WIDTH-1:0] size);
    case (size)
      SIZE_WIDTH'(0): byte_mask = 4'b0001 << off;
      SIZE_WIDTH'(1): byte_mask = 4'b0011 << off;
      default:        byte_mask = 4'b1111;
    endcase
  endfunction

  // Oldest-to-youngest overlay so the youngest store wins each byte lane
  always_comb begin
    merged = sb.bus_stbuf_read_data;
    lanes  = '0;
    bmask  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lanes = ent_data[slot[k]] << {ent_addr[slot[k]][1:0], 3'b000};
      bmask = byte_mask(ent_addr[slot[k]][1:0], ent_size[slot[k]]);
      for (int j = 0; j < 4; j++) begin
        if (hit[k] && bmask[j]) merged[8*j +: 8] = lanes[8*j +: 8];
      end
    end
  end

  assign load_word = merged;
  assign load_ok   = 1'b1;
`else
  // Without forwarding, any buffered store to the word holds the load off
  assign load_word = sb.bus_stbuf_read_data;
  assign load_ok   = (hit == '0);
`endif

  function automatic logic [BUS_DATA_WIDTH-1:0] size_mask(input logic [SIZE_WIDTH-1:0] size);
    case (size)
      SIZE_WIDTH'(0): size_mask = {{(BUS_DATA_WIDTH-8){1'b0}}, 8'hFF};
      SIZE_WIDTH'(1): size_mask = {{(BUS_DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      default:        size_mask = '1;
    endcase
  endfunction

  // Right-justify and zero-extend the loaded value
  assign shifted = load_word >> {sb.exlsu_stbuf_read_addr[1:0], 3'b000};
  assign sb.stbuf_exlsu_bus_data_feedback = shifted & size_mask(sb.exlsu_stbuf_read_size);
  assign sb.stbuf_exlsu_bus_ready = sb.exlsu_stbuf_read_req && sb.bus_stbuf_read_ready && load_ok;
endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed steps plus a randomized phase, checked
// against a queue-based model of speculative and committed stores.
module tb_store_buffer;
  localparam int DEPTH = 16;
  localparam int EW    = 71;

  typedef struct packed {
    logic [4:0]  rob;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  store_buffer_if sif ();

  store_buffer dut (
    .clk (clk),
    .rst (rst),
    .sb  (sif)
  );

  // Clock
  always #5 clk = ~clk;

  // Model state: speculative stores, committed stores awaiting drain
  st_t             spec_q[$];
  logic [EW-1:0]   exp_q[$];
  int checks  = 0;
  int errors  = 0;
  int drained = 0;
  logic [4:0] rob_ctr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sif.exlsu_stbuf_rob_id     = '0;
    sif.exlsu_stbuf_write_addr = '0;
    sif.exlsu_stbuf_write_size = '0;
    sif.exlsu_stbuf_write_data = '0;
    sif.exlsu_stbuf_push       = 1'b0;
    sif.exlsu_stbuf_read_req   = 1'b0;
    sif.exlsu_stbuf_read_addr  = '0;
    sif.exlsu_stbuf_read_size  = '0;
    sif.commit_stbuf_retire    = 1'b0;
    sif.commit_stbuf_rob_id    = '0;
    sif.commit_stbuf_flush     = 1'b0;
    sif.bus_stbuf_read_data    = '0;
    sif.bus_stbuf_read_ready   = 1'b0;
    sif.bus_stbuf_write_ack    = 1'b0;
  endtask

  task automatic drive_push(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    sif.exlsu_stbuf_push       = 1'b1;
    sif.exlsu_stbuf_rob_id     = rob_ctr;
    sif.exlsu_stbuf_write_addr = addr;
    sif.exlsu_stbuf_write_size = size;
    sif.exlsu_stbuf_write_data = data;
    rob_ctr = rob_ctr + 5'd1;
  endtask

  task automatic drive_retire();
    if (spec_q.size() > 0) begin
      sif.commit_stbuf_retire = 1'b1;
      sif.commit_stbuf_rob_id = spec_q[0].rob;
    end
  endtask

  // Check drain/full state, advance one clock, then apply the same cycle to the model
  task automatic tick();
    bit p_full, p_req;
    st_t h, e;
    #1;
    p_full = (exp_q.size() + spec_q.size()) == DEPTH;
    p_req  = exp_q.size() != 0;
    check("full", 32'(sif.stbuf_exlsu_full), 32'(p_full));
    check("write_req", 32'(sif.stbuf_bus_write_req), 32'(p_req));
    if (p_req) begin
      h = exp_q[0];
      check("write_addr", sif.stbuf_bus_write_addr, h.addr);
      check("write_size", 32'(sif.stbuf_bus_write_size), 32'(h.size));
      check("write_data", sif.stbuf_bus_write_data, h.data);
    end
    @(posedge clk);
    if (p_req && sif.bus_stbuf_write_ack) begin
      void'(exp_q.pop_front());
      drained++;
    end
    if (sif.commit_stbuf_retire && spec_q.size() > 0) begin
      e = spec_q.pop_front();
      exp_q.push_back(e);
    end
    if (sif.exlsu_stbuf_push && !p_full && !sif.commit_stbuf_flush) begin
      e.rob  = sif.exlsu_stbuf_rob_id;
      e.addr = sif.exlsu_stbuf_write_addr;
      e.size = sif.exlsu_stbuf_write_size;
      e.data = sif.exlsu_stbuf_write_data;
      spec_q.push_back(e);
    end
    if (sif.commit_stbuf_flush) spec_q.delete();
    @(negedge clk);
    sif.exlsu_stbuf_push    = 1'b0;
    sif.commit_stbuf_retire = 1'b0;
    sif.commit_stbuf_flush  = 1'b0;
  endtask

  // Reference load: overlay every buffered store byte, oldest first
  task automatic model_load(input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] bus, output logic [31:0] fb, output bit hit);
    logic [7:0] b [4];
    logic [31:0] word;
    st_t all[$];
    st_t e;
    int n;
    foreach (exp_q[i]) begin e = exp_q[i]; all.push_back(e); end
    foreach (spec_q[i]) all.push_back(spec_q[i]);
    for (int j = 0; j < 4; j++) b[j] = bus[8*j +: 8];
    hit = 1'b0;
    foreach (all[i]) begin
      if (all[i].addr[31:2] == addr[31:2]) begin
        hit = 1'b1;
        n = (all[i].size == 2'd0) ? 1 : (all[i].size == 2'd1) ? 2 : 4;
        for (int j = 0; j < n; j++) b[int'(all[i].addr[1:0]) + j] = all[i].data[8*j +: 8];
      end
    end
`ifdef STBUF_FORWARD_EN
    word = {b[3], b[2], b[1], b[0]};
`else
    word = bus;
`endif
    word = word >> (8 * int'(addr[1:0]));
    if (size == 2'd0) fb = word & 32'hFF;
    else if (size == 2'd1) fb = word & 32'hFFFF;
    else fb = word;
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] bus, input logic rdy);
    logic [31:0] fb;
    bit hit;
    bit exp_ready;
    sif.exlsu_stbuf_read_req  = 1'b1;
    sif.exlsu_stbuf_read_addr = addr;
    sif.exlsu_stbuf_read_size = size;
    sif.bus_stbuf_read_data   = bus;
    sif.bus_stbuf_read_ready  = rdy;
    #1;
    model_load(addr, size, bus, fb, hit);
`ifdef STBUF_FORWARD_EN
    exp_ready = rdy;
`else
    exp_ready = rdy && !hit;
`endif
    check({tag, "_feedback"}, sif.stbuf_exlsu_bus_data_feedback, fb);
    check({tag, "_ready"}, 32'(sif.stbuf_exlsu_bus_ready), 32'(exp_ready));
    check({tag, "_rd_addr"}, sif.stbuf_bus_read_addr, {addr[31:2], 2'b00});
    check({tag, "_rd_req"}, 32'(sif.stbuf_bus_read_req), 32'd1);
    check({tag, "_raw"}, sif.stbuf_exlsu_bus_data, bus);
    sif.exlsu_stbuf_read_req = 1'b0;
    sif.bus_stbuf_read_ready = 1'b0;
    sif.bus_stbuf_read_data  = '0;
  endtask

  task automatic rand_store(output logic [31:0] addr, output logic [1:0] size, output logic [31:0] data);
    size = 2'($urandom_range(0, 2));
    addr = 32'h200 + 32'(4 * $urandom_range(0, 3));
    if (size == 2'd0) begin addr = addr + 32'($urandom_range(0, 3)); data = $urandom & 32'hFF; end
    else if (size == 2'd1) begin addr = addr + 32'(2 * $urandom_range(0, 1)); data = $urandom & 32'hFFFF; end
    else data = $urandom;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    sif.bus_stbuf_write_ack = 1'b1;
    while ((spec_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
      drive_retire();
      tick();
      n++;
    end
    check("drain_bound", 32'(n < 200), 32'd1);
    sif.bus_stbuf_write_ack = 1'b0;
    tick();
  endtask

  initial begin : stimulus
    logic [31:0] a, d, fb_exp;
    logic [1:0]  s;
    int d0;

    // Reset state
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_full", 32'(sif.stbuf_exlsu_full), 32'd0);
    check("rst_write_req", 32'(sif.stbuf_bus_write_req), 32'd0);
    check("rst_write_addr", sif.stbuf_bus_write_addr, 32'd0);
    check("rst_read_req", 32'(sif.stbuf_bus_read_req), 32'd0);
    check("rst_ready", 32'(sif.stbuf_exlsu_bus_ready), 32'd0);
    check("rst_feedback", sif.stbuf_exlsu_bus_data_feedback, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fill: 16 word stores with ack low, then a 17th that must be ignored
    for (int i = 0; i < 17; i++) begin
      drive_push(32'h1000 + 32'(4 * i), 2'd2, $urandom);
      tick();
    end
    check("fill_full", 32'(sif.stbuf_exlsu_full), 32'd1);
    check("fill_count", 32'(spec_q.size()), 32'd16);
    d0 = drained;
    drain_all();
    check("fill_drained", 32'(drained - d0), 32'd16);

    // Single word store: push, retire, ack next cycle
    drive_push(32'h100, 2'd2, 32'hAABBCCDD);
    tick();
    drive_retire();
    tick();
    #1;
    check("sw_req", 32'(sif.stbuf_bus_write_req), 32'd1);
    check("sw_addr", sif.stbuf_bus_write_addr, 32'h100);
    check("sw_size", 32'(sif.stbuf_bus_write_size), 32'd2);
    check("sw_data", sif.stbuf_bus_write_data, 32'hAABBCCDD);
    sif.bus_stbuf_write_ack = 1'b1;
    tick();
    sif.bus_stbuf_write_ack = 1'b0;
    #1;
    check("sw_after_req", 32'(sif.stbuf_bus_write_req), 32'd0);
    check("sw_after_full", 32'(sif.stbuf_exlsu_full), 32'd0);
    tick();

    // Byte-merge load over sb 0x101 and sh 0x102
    drive_push(32'h101, 2'd0, 32'h11);
    tick();
    drive_push(32'h102, 2'd1, 32'h2233);
    tick();
    load_check("merge_lw", 32'h100, 2'd2, 32'h99887766, 1'b1);
    sif.exlsu_stbuf_read_req = 1'b1; sif.exlsu_stbuf_read_addr = 32'h100;
    sif.exlsu_stbuf_read_size = 2'd2; sif.bus_stbuf_read_data = 32'h99887766;
    sif.bus_stbuf_read_ready = 1'b1;
    #1;
`ifdef STBUF_FORWARD_EN
    check("merge_const_fb", sif.stbuf_exlsu_bus_data_feedback, 32'h22331166);
    check("merge_const_ready", 32'(sif.stbuf_exlsu_bus_ready), 32'd1);
`else
    check("merge_const_ready", 32'(sif.stbuf_exlsu_bus_ready), 32'd0);
`endif
    load_check("merge_lb", 32'h103, 2'd0, 32'h99887766, 1'b1);
    load_check("other_word", 32'h104, 2'd1, 32'h55443322, 1'b1);
    sif.commit_stbuf_flush = 1'b1;
    tick();

    // Push 3, retire 1, flush with a same-cycle push
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h300 + 32'(4 * i), 2'd2, 32'hC0DE0000 + 32'(i));
      tick();
    end
    drive_retire();
    tick();
    sif.commit_stbuf_flush = 1'b1;
    drive_push(32'h400, 2'd2, 32'hDEADBEEF);
    tick();
    check("flush_count", 32'(spec_q.size() + exp_q.size()), 32'd1);
    #1;
    check("flush_drain_addr", sif.stbuf_bus_write_addr, 32'h300);
    d0 = drained;
    drain_all();
    check("flush_drained", 32'(drained - d0), 32'd1);

    // Randomized traffic with wrap, loads, occasional flush
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 3) != 0) begin rand_store(a, s, d); drive_push(a, s, d); end
      if ($urandom_range(0, 2) != 0) drive_retire();
      sif.bus_stbuf_write_ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) sif.commit_stbuf_flush = 1'b1;
      rand_store(a, s, d);
      load_check("rand_load", a, s, $urandom, 1'($urandom_range(0, 1)));
      tick();
    end
    drain_all();

    // Reset while a drain write is pending
    drive_push(32'h500, 2'd2, 32'h01020304);
    tick();
    drive_retire();
    tick();
    #1;
    check("mid_req_before", 32'(sif.stbuf_bus_write_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_req_after", 32'(sif.stbuf_bus_write_req), 32'd0);
    check("mid_full_after", 32'(sif.stbuf_exlsu_full), 32'd0);
    spec_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_check("post_rst", 32'h500, 2'd2, 32'h12345678, 1'b1);
    sif.exlsu_stbuf_read_req = 1'b1; sif.exlsu_stbuf_read_addr = 32'h502;
    sif.exlsu_stbuf_read_size = 2'd1; sif.bus_stbuf_read_data = 32'h12345678;
    sif.bus_stbuf_read_ready = 1'b1;
    #1;
    fb_exp = 32'h1234;
    check("post_rst_half", sif.stbuf_exlsu_bus_data_feedback, fb_exp);
    check("post_rst_ready", 32'(sif.stbuf_exlsu_bus_ready), 32'd1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
